// File: rtl/ldpc_frame_loader_if.sv
// Channel-sample stream and intrinsic write-beat bus between the LLR source,
// the frame loader and the PE block intrinsic banks.
interface ldpc_frame_loader_if #(
  parameter int ADDR_WIDTH    = 5,
  parameter int NUM_PE        = 24,
  parameter int IN_WIDTH      = 8,
  parameter int MESSAGE_WIDTH = 5
);
  logic [IN_WIDTH-1:0]      in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     load_valid;
  logic [ADDR_WIDTH-1:0]    load_add;
  logic [MESSAGE_WIDTH-1:0] int_data;
  logic [NUM_PE-1:0]        pe_select;

  // Environment side: drives LLR samples, observes the write beats.
  modport master (
    output in_data, in_valid,
    input  in_ready, load_valid, load_add, int_data, pe_select
  );

  // Loader side.
  modport slave (
    input  in_data, in_valid,
    output in_ready, load_valid, load_add, int_data, pe_select
  );
endinterface

// File: rtl/ldpc_frame_loader.sv
// Loads one codeword frame of saturated channel LLRs into the idle intrinsic
// bank of the PE blocks, then stalls until the decoder flips its frame id.
module ldpc_frame_loader #(
  parameter int L             = 32,
  parameter int ADDR_WIDTH    = 5,
  parameter int NUM_PE        = 24,
  parameter int IN_WIDTH      = 8,
  parameter int MESSAGE_WIDTH = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  ldpc_frame_loader_if.slave  bus,
  input  logic                f_id,
  output logic                frame_done,
  output logic [7:0]          frame_count,
  output logic                err_overrun
);

  localparam int PE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic signed [IN_WIDTH-1:0] SAT_POS = IN_WIDTH'((1 << (MESSAGE_WIDTH-1)) - 1);
  localparam logic signed [IN_WIDTH-1:0] SAT_NEG = -SAT_POS;

  typedef enum logic {LOAD, WAIT_SWAP} state_t;

  state_t                   state, state_next;
  logic [ADDR_WIDTH-1:0]    word_cnt;
  logic [PE_W-1:0]          pe_cnt;
  logic                     f_id_q;
  logic                     accept, toggle, last_word, last_sample;
  logic signed [IN_WIDTH-1:0] sample;
  logic [MESSAGE_WIDTH-1:0] sat_data;

  assign bus.in_ready = (state == LOAD);
  assign accept       = bus.in_valid & bus.in_ready;
  assign toggle       = f_id ^ f_id_q;
  assign last_word    = (word_cnt == ADDR_WIDTH'(L-1));
  assign last_sample  = last_word && (pe_cnt == PE_W'(NUM_PE-1));
  assign sample       = signed'(bus.in_data);

  // Symmetric clamp keeps the most negative code out of the PE message space.
  always_comb begin
    // NOTE: default first so every path assigns sat_data and no latch is inferred.
    sat_data = sample[MESSAGE_WIDTH-1:0];
    if (sample > SAT_POS)
      sat_data = SAT_POS[MESSAGE_WIDTH-1:0];
    else if (sample < SAT_NEG)
      sat_data = SAT_NEG[MESSAGE_WIDTH-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:      if (accept && last_sample) state_next = WAIT_SWAP;
      WAIT_SWAP: if (toggle)                state_next = LOAD;
      default:                              state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state    <= LOAD;
      f_id_q   <= 1'b0;
      word_cnt <= '0;
      pe_cnt   <= '0;
    end else begin
      state  <= state_next;
      f_id_q <= f_id;
      if (accept) begin
        if (last_sample) begin
          word_cnt <= '0;
          pe_cnt   <= '0;
        end else if (last_word) begin
          word_cnt <= '0;
          pe_cnt   <= pe_cnt + PE_W'(1);
        end else begin
          word_cnt <= word_cnt + ADDR_WIDTH'(1);
        end
      end
    end
  end

  // Write beat and frame status are registered one edge after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.load_valid <= 1'b0;
      bus.load_add   <= '0;
      bus.int_data   <= '0;
      bus.pe_select  <= '0;
      frame_done     <= 1'b0;
      frame_count    <= 8'd0;
      err_overrun    <= 1'b0;
    end else begin
      bus.load_valid <= accept;
      bus.pe_select  <= accept ? (NUM_PE'(1) << pe_cnt) : '0;
      frame_done     <= accept && last_sample;
      if (accept) begin
        bus.load_add <= word_cnt;
        bus.int_data <= sat_data;
      end
      if (accept && last_sample)
        frame_count <= frame_count + 8'd1;
      // A toggle while loading means the bank was released under us; the
      // frame keeps loading but the swap request is not remembered.
      if (toggle && state == LOAD)
        err_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ldpc_frame_loader.sv
// Directed bench for ldpc_frame_loader: full frames, saturation, swap stall,
// overrun, in_valid gaps and mid-frame reset.
module tb_ldpc_frame_loader;

  localparam int N = 768;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       f_id = 1'b0;
  logic       frame_done;
  logic [7:0] frame_count;
  logic       err_overrun;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [23:0] pe;
    logic [4:0]  add;
    logic [4:0]  data;
    logic        done;
  } beat_t;

  beat_t      beats[$];
  logic [7:0] stim[N];
  logic [4:0] exp_int[N];

  ldpc_frame_loader_if bus ();

  ldpc_frame_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .f_id        (f_id),
    .frame_done  (frame_done),
    .frame_count (frame_count),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && bus.load_valid)
      beats.push_back('{pe: bus.pe_select, add: bus.load_add,
                        data: bus.int_data, done: frame_done});

  task automatic fill_ramp();
    for (int k = 0; k < N; k++) begin
      stim[k]    = 8'(k % 16);
      exp_int[k] = 5'(k % 16);
    end
  endtask

  // Offers samples first..last-1; optionally flips f_id when sample toggle_at is next.
  task automatic send(input int first, input int last, input bit gaps, input int toggle_at);
    int  k = first;
    int  cyc = 0;
    bit  toggled = 1'b0;
    while (k < last && cyc < 4 * (last - first) + 50) begin
      @(negedge clk);
      if (!toggled && k == toggle_at) begin
        f_id    = ~f_id;
        toggled = 1'b1;
      end
      bus.in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data  = stim[k];
      if (bus.in_valid && bus.in_ready) k++;
      cyc++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (k != last) begin
      errors++;
      $display("FAIL send_timeout: accepted up to %0d, required %0d", k, last);
    end
  endtask

  task automatic swap();
    @(negedge clk);
    f_id = ~f_id;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.load_valid, bus.load_add, bus.int_data, bus.pe_select,
         frame_done, frame_count, err_overrun} !== {1'b1, 1'b0, 5'd0, 5'd0, 24'd0, 1'b0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: rdy=%b lv=%b add=%0d int=%h pe=%h done=%b cnt=%0d ovr=%b, required rdy=1 rest 0",
               bus.in_ready, bus.load_valid, bus.load_add, bus.int_data, bus.pe_select,
               frame_done, frame_count, err_overrun);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_frame();
    fill_ramp();
    beats.delete();
    send(0, N, 1'b0, -1);
    repeat (2) @(negedge clk);
    checks++;
    if (beats.size() != N) begin
      errors++;
      $display("FAIL full_beat_count: got %0d, required %0d", beats.size(), N);
    end
    for (int k = 0; k < beats.size() && k < N; k++) begin
      checks++;
      if (beats[k].pe !== (24'(1) << (k / 32)) || beats[k].add !== 5'(k % 32) ||
          beats[k].data !== exp_int[k] || beats[k].done !== (k == N - 1)) begin
        errors++;
        $display("FAIL full_beat%0d: pe=%h add=%0d int=%h done=%b, required pe=%h add=%0d int=%h done=%b",
                 k, beats[k].pe, beats[k].add, beats[k].data, beats[k].done,
                 24'(1) << (k / 32), k % 32, exp_int[k], k == N - 1);
      end
    end
    checks++;
    if (frame_count !== 8'd1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_after: cnt=%0d rdy=%b, required cnt=1 rdy=0", frame_count, bus.in_ready);
    end
  endtask

  task automatic test_wait_swap();
    beats.delete();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd3;
    repeat (100) @(negedge clk);
    checks++;
    if (beats.size() != 0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL wait_stall: beats=%0d rdy=%b, required beats=0 rdy=0", beats.size(), bus.in_ready);
    end
    bus.in_valid = 1'b0;
    f_id = ~f_id;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL swap_early: rdy=%b, required 0", bus.in_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL swap_ready: rdy=%b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_gaps();
    beats.delete();
    send(0, N, 1'b1, -1);
    repeat (2) @(negedge clk);
    checks++;
    if (beats.size() != N) begin
      errors++;
      $display("FAIL gaps_beat_count: got %0d, required %0d", beats.size(), N);
    end
    for (int k = 0; k < beats.size() && k < N; k++) begin
      checks++;
      if (beats[k].pe !== (24'(1) << (k / 32)) || beats[k].add !== 5'(k % 32) ||
          beats[k].data !== exp_int[k] || beats[k].done !== (k == N - 1)) begin
        errors++;
        $display("FAIL gaps_beat%0d: pe=%h add=%0d int=%h done=%b, required pe=%h add=%0d int=%h done=%b",
                 k, beats[k].pe, beats[k].add, beats[k].data, beats[k].done,
                 24'(1) << (k / 32), k % 32, exp_int[k], k == N - 1);
      end
    end
    checks++;
    if (frame_count !== 8'd2) begin
      errors++;
      $display("FAIL gaps_count: cnt=%0d, required 2", frame_count);
    end
  endtask

  task automatic test_overrun();
    swap();
    checks++;
    if (err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clean: ovr=%b, required 0", err_overrun);
    end
    beats.delete();
    send(0, N, 1'b0, 400);
    repeat (2) @(negedge clk);
    checks++;
    if (err_overrun !== 1'b1 || beats.size() != N || frame_count !== 8'd3) begin
      errors++;
      $display("FAIL overrun_frame: ovr=%b beats=%0d cnt=%0d, required ovr=1 beats=%0d cnt=3",
               err_overrun, beats.size(), frame_count, N);
    end
    checks++;
    if (beats.size() == N && (beats[N-1].done !== 1'b1 || beats[N-1].pe !== 24'h800000 || beats[N-1].add !== 5'd31)) begin
      errors++;
      $display("FAIL overrun_last: done=%b pe=%h add=%0d, required done=1 pe=800000 add=31",
               beats[N-1].done, beats[N-1].pe, beats[N-1].add);
    end
    bus.in_valid = 1'b1;
    repeat (10) @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0 || beats.size() != N || err_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_stall: rdy=%b beats=%0d ovr=%b, required rdy=0 beats=%0d ovr=1",
               bus.in_ready, beats.size(), err_overrun, N);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] vin [7];
    logic [4:0] vexp[7];
    vin  = '{8'h7F, 8'h0F, 8'h10, 8'hF1, 8'hF0, 8'h80, 8'h00};
    vexp = '{5'h0F, 5'h0F, 5'h0F, 5'h11, 5'h11, 5'h11, 5'h00};
    swap();
    fill_ramp();
    for (int i = 0; i < 7; i++) stim[i] = vin[i];
    beats.delete();
    send(0, 7, 1'b0, -1);
    @(negedge clk);
    checks++;
    if (beats.size() != 7) begin
      errors++;
      $display("FAIL sat_beat_count: got %0d, required 7", beats.size());
    end
    for (int i = 0; i < 7 && i < beats.size(); i++) begin
      checks++;
      if (beats[i].data !== vexp[i] || beats[i].add !== 5'(i) || beats[i].pe !== 24'd1) begin
        errors++;
        $display("FAIL sat%0d: in=%h int=%h add=%0d pe=%h, required int=%h add=%0d pe=1",
                 i, vin[i], beats[i].data, beats[i].add, beats[i].pe, vexp[i], i);
      end
    end
  endtask

  task automatic test_reset_mid();
    send(7, 300, 1'b0, -1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.load_valid, bus.load_add, bus.int_data, bus.pe_select,
         frame_done, frame_count, err_overrun} !== {1'b1, 1'b0, 5'd0, 5'd0, 24'd0, 1'b0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_values: rdy=%b lv=%b add=%0d int=%h pe=%h done=%b cnt=%0d ovr=%b, required rdy=1 rest 0",
               bus.in_ready, bus.load_valid, bus.load_add, bus.int_data, bus.pe_select,
               frame_done, frame_count, err_overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    fill_ramp();
    beats.delete();
    send(0, N, 1'b0, -1);
    repeat (2) @(negedge clk);
    checks++;
    if (beats.size() != N || beats[0].pe !== 24'd1 || beats[0].add !== 5'd0 ||
        beats[N-1].done !== 1'b1 || frame_count !== 8'd1) begin
      errors++;
      $display("FAIL midreset_restart: beats=%0d pe0=%h add0=%0d cnt=%0d, required beats=%0d pe0=1 add0=0 cnt=1",
               beats.size(), beats[0].pe, beats[0].add, frame_count, N);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    test_reset();
    test_full_frame();
    test_wait_swap();
    test_gaps();
    test_overrun();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
